// File: rtl/operand_entry_fsm_if.sv
// Bundle of raw board inputs and committed adder operands for the entry stage.
// master = entry FSM side, slave = board/display side.
interface operand_entry_fsm_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sw;
  logic             sw_cin;
  logic             key_next_n;
  logic             key_clear_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             operands_valid;
  logic [1:0]       state;
  logic [WIDTH-1:0] preview;

  modport master (
    input  sw, sw_cin, key_next_n, key_clear_n,
    output a, b, cin, operands_valid, state, preview
  );

  modport slave (
    output sw, sw_cin, key_next_n, key_clear_n,
    input  a, b, cin, operands_valid, state, preview
  );
endinterface

// File: rtl/operand_entry_fsm.sv
// Operand entry stage for the 4-bit adder: synchronises switches, debounces two
// active-low keys and steps LOAD_A -> LOAD_B -> READY on each accepted press.
module operand_entry_fsm #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  operand_entry_fsm_if.master bus
);

  localparam int NKEYS     = 2;
  localparam int KEY_NEXT  = 0;
  localparam int KEY_CLEAR = 1;
  localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'b00,
    ST_LOAD_B = 2'b01,
    ST_READY  = 2'b10
  } state_t;

  // Switch synchronisers; the second stage doubles as the display preview.
  logic [WIDTH-1:0] sw_meta_reg;
  logic [WIDTH-1:0] sw_sync_reg;
  logic             cin_meta_reg;
  logic             cin_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      cin_meta_reg <= 1'b0;
      cin_sync_reg <= 1'b0;
    end else begin
      sw_meta_reg  <= bus.sw;
      sw_sync_reg  <= sw_meta_reg;
      cin_meta_reg <= bus.sw_cin;
      cin_sync_reg <= cin_meta_reg;
    end
  end

  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_press;

  assign key_raw = {bus.key_clear_n, bus.key_next_n};

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic             meta_reg;
      logic             sync_reg;
      logic             db_reg;
      logic             db_d_reg;
      logic             press_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Any return to the accepted level restarts the count, so only a level
      // held for DEBOUNCE_CYCLES consecutive cycles is taken.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg  <= 1'b1;
          sync_reg  <= 1'b1;
          db_reg    <= 1'b1;
          db_d_reg  <= 1'b1;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          meta_reg <= key_raw[gi];
          sync_reg <= meta_reg;
          if (sync_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            db_reg  <= sync_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          db_d_reg  <= db_reg;
          press_reg <= db_d_reg & ~db_reg;
        end
      end

      assign key_press[gi] = press_reg;
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             cin_reg, cin_next;
  logic             valid_reg, valid_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_LOAD_A;
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      cin_reg   <= cin_next;
      valid_reg <= valid_next;
    end
  end

  // Clear is tested first so a coincident next press is dropped.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    cin_next   = cin_reg;
    valid_next = valid_reg;
    if (key_press[KEY_CLEAR]) begin
      state_next = ST_LOAD_A;
      a_next     = '0;
      b_next     = '0;
      cin_next   = 1'b0;
      valid_next = 1'b0;
    end else if (key_press[KEY_NEXT]) begin
      case (state_reg)
        ST_LOAD_A: begin
          a_next     = sw_sync_reg;
          state_next = ST_LOAD_B;
        end
        ST_LOAD_B: begin
          b_next     = sw_sync_reg;
          cin_next   = cin_sync_reg;
          valid_next = 1'b1;
          state_next = ST_READY;
        end
        ST_READY: begin
          valid_next = 1'b0;
          state_next = ST_LOAD_A;
        end
        default: begin
          valid_next = 1'b0;
          state_next = ST_LOAD_A;
        end
      endcase
    end
  end

  assign bus.a              = a_reg;
  assign bus.b              = b_reg;
  assign bus.cin            = cin_reg;
  assign bus.operands_valid = valid_reg;
  assign bus.state          = state_reg;
  assign bus.preview        = sw_sync_reg;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm with a 4-cycle debounce window.
module tb_operand_entry_fsm;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks    = 0;
  int   failures  = 0;
  int   trans_cnt = 0;

  operand_entry_fsm_if #(.WIDTH(WIDTH)) bus ();

  operand_entry_fsm #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Counts every change of the state code so repeats/glitches are visible.
  always @(bus.state) trans_cnt = trans_cnt + 1;

  task automatic apply_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.sw          = '0;
    bus.sw_cin      = 1'b0;
    bus.key_next_n  = 1'b1;
    bus.key_clear_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Press one key (0 = next, 1 = clear) for hold cycles, then let it settle released.
  task automatic press_key(input bit clear, input int hold);
    @(negedge clk);
    if (clear) bus.key_clear_n = 1'b0;
    else       bus.key_next_n  = 1'b0;
    repeat (hold) @(negedge clk);
    bus.key_next_n  = 1'b1;
    bus.key_clear_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.sw          = 4'hA;
    bus.sw_cin      = 1'b1;
    bus.key_next_n  = 1'b1;
    bus.key_clear_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.preview !== 4'h0) begin
      failures++;
      $display("FAIL reset_preview_held got=%h exp=%h", bus.preview, 4'h0);
    end
    rst_n = 1'b1;
    bus.sw = '0;
    bus.sw_cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.a !== 4'h0 || bus.b !== 4'h0 || bus.cin !== 1'b0) begin
      failures++;
      $display("FAIL reset_operands got a=%h b=%h cin=%b exp a=0 b=0 cin=0", bus.a, bus.b, bus.cin);
    end
    checks++;
    if (bus.operands_valid !== 1'b0 || bus.state !== 2'b00) begin
      failures++;
      $display("FAIL reset_state got valid=%b state=%b exp valid=0 state=00", bus.operands_valid, bus.state);
    end
    $display("test_reset: a=%h b=%h cin=%b valid=%b state=%b", bus.a, bus.b, bus.cin, bus.operands_valid, bus.state);
  endtask

  task automatic test_basic_entry();
    apply_reset();
    @(negedge clk);
    bus.sw = 4'h3;
    bus.key_next_n = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.state !== 2'b00) begin
      failures++;
      $display("FAIL basic_a_early got state=%b exp=00", bus.state);
    end
    @(negedge clk);
    checks++;
    if (bus.a !== 4'h3 || bus.state !== 2'b01 || bus.operands_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_load_a got a=%h state=%b valid=%b exp a=3 state=01 valid=0", bus.a, bus.state, bus.operands_valid);
    end
    bus.key_next_n = 1'b1;
    repeat (12) @(negedge clk);
    bus.sw = 4'h5;
    bus.sw_cin = 1'b1;
    bus.key_next_n = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.state !== 2'b01 || bus.operands_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_b_early got state=%b valid=%b exp state=01 valid=0", bus.state, bus.operands_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.b !== 4'h5 || bus.cin !== 1'b1 || bus.operands_valid !== 1'b1 || bus.state !== 2'b10 || bus.a !== 4'h3) begin
      failures++;
      $display("FAIL basic_load_b got a=%h b=%h cin=%b valid=%b state=%b exp a=3 b=5 cin=1 valid=1 state=10",
               bus.a, bus.b, bus.cin, bus.operands_valid, bus.state);
    end
    bus.key_next_n = 1'b1;
    repeat (12) @(negedge clk);
    $display("test_basic_entry: a=%h b=%h cin=%b valid=%b state=%b", bus.a, bus.b, bus.cin, bus.operands_valid, bus.state);
  endtask

  task automatic test_bounce();
    int base;
    apply_reset();
    base = trans_cnt;
    bus.sw = 4'h7;
    for (int i = 0; i < 5; i++) begin
      bus.key_next_n = 1'b0;
      repeat (3) @(negedge clk);
      bus.key_next_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (trans_cnt - base !== 0 || bus.state !== 2'b00 || bus.a !== 4'h0) begin
      failures++;
      $display("FAIL bounce_reject got transitions=%0d state=%b a=%h exp transitions=0 state=00 a=0", trans_cnt - base, bus.state, bus.a);
    end
    press_key(1'b0, 8);
    checks++;
    if (trans_cnt - base !== 1 || bus.state !== 2'b01 || bus.a !== 4'h7) begin
      failures++;
      $display("FAIL bounce_accept got transitions=%0d state=%b a=%h exp transitions=1 state=01 a=7", trans_cnt - base, bus.state, bus.a);
    end
    $display("test_bounce: transitions=%0d state=%b a=%h", trans_cnt - base, bus.state, bus.a);
  endtask

  task automatic test_hold();
    int base;
    apply_reset();
    base = trans_cnt;
    bus.sw = 4'h9;
    @(negedge clk);
    bus.key_next_n = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (trans_cnt - base !== 1 || bus.state !== 2'b01 || bus.a !== 4'h9) begin
      failures++;
      $display("FAIL hold_single got transitions=%0d state=%b a=%h exp transitions=1 state=01 a=9", trans_cnt - base, bus.state, bus.a);
    end
    bus.key_next_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (trans_cnt - base !== 1 || bus.state !== 2'b01) begin
      failures++;
      $display("FAIL hold_release got transitions=%0d state=%b exp transitions=1 state=01", trans_cnt - base, bus.state);
    end
    $display("test_hold: transitions=%0d state=%b a=%h", trans_cnt - base, bus.state, bus.a);
  endtask

  task automatic test_ready();
    apply_reset();
    bus.sw = 4'h3;
    press_key(1'b0, 8);
    bus.sw = 4'h5;
    bus.sw_cin = 1'b1;
    press_key(1'b0, 8);
    bus.sw = 4'hF;
    @(negedge clk);
    checks++;
    if (bus.preview !== 4'h5) begin
      failures++;
      $display("FAIL ready_preview_1cyc got=%h exp=%h", bus.preview, 4'h5);
    end
    @(negedge clk);
    checks++;
    if (bus.preview !== 4'hF) begin
      failures++;
      $display("FAIL ready_preview_2cyc got=%h exp=%h", bus.preview, 4'hF);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.a !== 4'h3 || bus.b !== 4'h5 || bus.cin !== 1'b1 || bus.operands_valid !== 1'b1 || bus.state !== 2'b10) begin
      failures++;
      $display("FAIL ready_stable got a=%h b=%h cin=%b valid=%b state=%b exp a=3 b=5 cin=1 valid=1 state=10",
               bus.a, bus.b, bus.cin, bus.operands_valid, bus.state);
    end
    press_key(1'b0, 8);
    checks++;
    if (bus.operands_valid !== 1'b0 || bus.state !== 2'b00 || bus.a !== 4'h3 || bus.b !== 4'h5 || bus.cin !== 1'b1) begin
      failures++;
      $display("FAIL ready_next got a=%h b=%h cin=%b valid=%b state=%b exp a=3 b=5 cin=1 valid=0 state=00",
               bus.a, bus.b, bus.cin, bus.operands_valid, bus.state);
    end
    $display("test_ready: a=%h b=%h cin=%b valid=%b state=%b", bus.a, bus.b, bus.cin, bus.operands_valid, bus.state);
  endtask

  task automatic test_clear_priority();
    apply_reset();
    bus.sw = 4'h3;
    press_key(1'b0, 8);
    bus.sw = 4'h5;
    bus.sw_cin = 1'b1;
    @(negedge clk);
    bus.key_next_n  = 1'b0;
    bus.key_clear_n = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.state !== 2'b01 || bus.a !== 4'h3) begin
      failures++;
      $display("FAIL clear_early got state=%b a=%h exp state=01 a=3", bus.state, bus.a);
    end
    @(negedge clk);
    checks++;
    if (bus.state !== 2'b00 || bus.a !== 4'h0 || bus.b !== 4'h0 || bus.cin !== 1'b0 || bus.operands_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_priority got a=%h b=%h cin=%b valid=%b state=%b exp all zero state=00",
               bus.a, bus.b, bus.cin, bus.operands_valid, bus.state);
    end
    bus.key_next_n  = 1'b1;
    bus.key_clear_n = 1'b1;
    repeat (12) @(negedge clk);
    bus.sw = 4'hC;
    press_key(1'b0, 8);
    bus.sw = 4'h6;
    press_key(1'b0, 8);
    press_key(1'b1, 8);
    checks++;
    if (bus.state !== 2'b00 || bus.a !== 4'h0 || bus.b !== 4'h0 || bus.cin !== 1'b0 || bus.operands_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_from_ready got a=%h b=%h cin=%b valid=%b state=%b exp all zero state=00",
               bus.a, bus.b, bus.cin, bus.operands_valid, bus.state);
    end
    $display("test_clear_priority: a=%h b=%h cin=%b valid=%b state=%b", bus.a, bus.b, bus.cin, bus.operands_valid, bus.state);
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    bus.sw = 4'h6;
    press_key(1'b0, 8);
    @(negedge clk);
    bus.key_next_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 2'b00 || bus.a !== 4'h0 || bus.operands_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async got state=%b a=%h valid=%b exp state=00 a=0 valid=0", bus.state, bus.a, bus.operands_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = trans_cnt;
    bus.sw = 4'hA;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.state !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_early got state=%b exp=00", bus.state);
    end
    @(negedge clk);
    checks++;
    if (bus.state !== 2'b01 || bus.a !== 4'hA) begin
      failures++;
      $display("FAIL reset_mid_press got state=%b a=%h exp state=01 a=a", bus.state, bus.a);
    end
    bus.key_next_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (trans_cnt - base !== 1) begin
      failures++;
      $display("FAIL reset_mid_count got transitions=%0d exp=1", trans_cnt - base);
    end
    $display("test_reset_mid: transitions=%0d state=%b a=%h", trans_cnt - base, bus.state, bus.a);
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_bounce();
    test_hold();
    test_ready();
    test_clear_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
- Upstream stage of the 4-bit hardware adder datapath.
- Converts raw board switches and two raw pushbuttons into stable, registered operands `a`, `b` and `cin` for the adder.
- Synchronises and debounces both keys, then walks a small entry state machine: load A, then load B (with carry-in), then result ready.
- Also drives a live preview of the switches and a state code, so the 7-segment/LED layer can show what is being entered.

Parameters:
- WIDTH, 4, operand width in bits; drives `sw`, `a`, `b`, `preview`.
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised key level must hold before it is accepted (10 ms at 50 MHz); legal range 2 or more.

Ports:
- clk  input  1  system clock, single domain.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  WIDTH  raw operand switches (asynchronous).
- sw_cin  input  1  raw carry-in switch (asynchronous).
- key_next_n  input  1  raw pushbutton, active-low; advances entry.
- key_clear_n  input  1  raw pushbutton, active-low; aborts entry.
- a  output  WIDTH  registered operand A to the adder.
- b  output  WIDTH  registered operand B to the adder.
- cin  output  1  registered carry-in to the adder.
- operands_valid  output  1  high while a/b/cin form a complete, committed pair.
- state  output  2  00 = LOAD_A, 01 = LOAD_B, 10 = READY (11 unused).
- preview  output  WIDTH  registered copy of the synchronised `sw`, for display.

Behaviour:
- Reset (async assert, sync release):
  - a = 0, b = 0, cin = 0, operands_valid = 0, state = LOAD_A, preview = 0.
  - Sync flops reset to 1 (key released); debounced levels reset to 1; debounce counters reset to 0.
- Synchronisers:
  - Each of sw, sw_cin, key_next_n and key_clear_n passes through a 2-flop synchroniser.
  - preview = second sync stage of sw.
  - a/b/cin capture from the synchronised values only.
- Debounce, per key, independent instance:
  - Keeps a debounced level `db` and a counter of width ceil(log2(DEBOUNCE_CYCLES)).
  - If sync == db: counter cleared to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: db <= sync and counter <= 0.
  - Else: counter increments.
  - Any bounce back to db before acceptance restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Press detection:
  - A one-cycle registered pulse is generated on each debounced 1->0 transition.
  - Release (0->1) generates no pulse.
  - Holding a key produces exactly one pulse; there is no auto-repeat.
- Latency, with raw key low first sampled at edge 0 and held:
  - db falls at edge D+1 (D = DEBOUNCE_CYCLES).
  - Pulse is high after edge D+2.
  - FSM outputs update at edge D+3.
- FSM, acting only on press pulses:
  - LOAD_A + next: a <= sync sw, go to LOAD_B.
  - LOAD_B + next: b <= sync sw, cin <= sync sw_cin, operands_valid <= 1, go to READY.
  - READY + next: operands_valid <= 0, go to LOAD_A. a/b/cin retain their values until overwritten.
  - Any state + clear: a, b, cin <= 0, operands_valid <= 0, go to LOAD_A.
  - Clear and next pulses on the same cycle: clear wins and next is discarded.
- Output stability: operands_valid, a, b and cin change only on FSM transitions. Switch movement in READY does not alter a/b/cin.
- Reset mid-debounce or mid-entry: all state returns to reset values immediately. A key still held at reset release must be seen as released-then-pressed, i.e. it needs a full debounce to 0 before it is accepted.
- No arithmetic here: sw is captured bit-for-bit, with no wrap or saturation.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 unless noted.
- Basic entry:
  - sw=0x3, press next; sw=0x5, sw_cin=1, press next.
  - Required: a=0x3 after the first press, state=01; b=0x5, cin=1, operands_valid=1, state=10 after the second.
  - Each update lands exactly at edge 7 after the key first goes low.
- Bounce rejection:
  - Toggle key_next_n low/high for 3 cycles each, repeated 5 times.
  - Required: no state change and no pulse. Then hold low 6+ cycles: exactly one transition.
- Hold without repeat:
  - Hold key_next_n low for 100 cycles in LOAD_A.
  - Required: single LOAD_A->LOAD_B transition; release produces no transition.
- READY behaviour:
  - In READY with a=0x3, b=0x5, change sw to 0xF.
  - Required: a/b unchanged, valid=1, preview=0xF after 2 cycles. Then press next: valid=0, state=00, a=0x3.
- Clear priority:
  - Release both keys' debounce on the same cycle while in LOAD_B.
  - Required: state=00, a=b=cin=0, valid=0.
- Reset mid-operation:
  - Assert rst_n low mid-count with the key held, then release it while the key is still held.
  - Required: outputs zero, state=00 immediately; one transition only after D+3 further cycles.
